// File: rtl/wr_fram_pack.sv
// Write-side frame buffer packer: eight pixels per 256-bit RAM word, bursts announced by toggle.
// Define WR_FRAM_FLUSH_EN to have frame_start write out a partially filled word (zero padded).
module wr_fram_pack #(
   parameter int unsigned PIX_WIDTH  = 32,
   parameter int unsigned BUF_WIDTH  = 256,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned BURST_LEN  = 64
) (
   input  logic                  wr_clk,
   input  logic                  tb_wr_rst,
   input  logic                  frame_start,
   input  logic [PIX_WIDTH-1:0]  pix_data,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   output logic [BUF_WIDTH-1:0]  buf_wr_data,
   output logic [ADDR_WIDTH-1:0] buf_wr_addr,
   output logic                  buf_wr_en,
   output logic                  burst_req_tgl,
   output logic [ADDR_WIDTH-1:0] burst_addr,
   input  logic                  burst_done_tgl,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow
);
   localparam int unsigned LANES   = BUF_WIDTH / PIX_WIDTH;
   localparam int unsigned LANE_W  = $clog2(LANES);
   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam int unsigned FILL_W  = ADDR_WIDTH + 1;
   localparam int unsigned BURST_W = $clog2(BURST_LEN);
   localparam int unsigned HOLD_W  = (LANES - 1) * PIX_WIDTH;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                state, state_nxt;
   logic [HOLD_W-1:0]     lane_reg;
   logic [LANE_W-1:0]     lane_cnt, lane_idx;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_base;
   logic [FILL_W-1:0]     pend_cnt, fill_nxt;
   logic                  s1, s2, s3, done_q;
   logic                  accept, word_done, flush, wr_issue, pend_inc, req_fire, rd_adv;
   logic [BUF_WIDTH-1:0]  full_word, wr_word;

   // The last lane is never stored: it goes straight from pix_data into the word
   assign accept    = pix_valid && pix_ready;
   assign lane_idx  = frame_start ? '0 : lane_cnt;
   assign word_done = accept && !frame_start && (lane_cnt == LAST_LANE);
   assign full_word = {pix_data, lane_reg};

`ifdef WR_FRAM_FLUSH_EN
   logic [BUF_WIDTH-1:0] part_word;

   always_comb begin
      part_word = '0;
      for (int unsigned i = 0; i < LANES - 1; i++)
         if (LANE_W'(i) < lane_cnt)
            part_word[i*PIX_WIDTH +: PIX_WIDTH] = lane_reg[i*PIX_WIDTH +: PIX_WIDTH];
   end

   assign flush   = frame_start && (lane_cnt != '0);
   assign wr_word = flush ? part_word : full_word;
`else
   assign flush   = 1'b0;
   assign wr_word = full_word;
`endif

   assign wr_issue = word_done || flush;
   assign pend_inc = buf_wr_en && (buf_wr_addr[BURST_W-1:0] == {BURST_W{1'b1}});
   assign fill_nxt = fill_level + FILL_W'(wr_issue) - (done_q ? FILL_W'(BURST_LEN) : FILL_W'(0));

   // Pixel packing, RAM write port, occupancy and done-toggle synchronizer
   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         lane_reg    <= '0;
         lane_cnt    <= '0;
         wr_ptr      <= '0;
         buf_wr_en   <= 1'b0;
         buf_wr_data <= '0;
         buf_wr_addr <= '0;
         fill_level  <= '0;
         pix_ready   <= 1'b1;
         overflow    <= 1'b0;
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         buf_wr_en <= wr_issue;
         if (wr_issue) begin
            buf_wr_data <= wr_word;
            buf_wr_addr <= wr_ptr;
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (accept) begin
            for (int unsigned i = 0; i < LANES - 1; i++)
               if (LANE_W'(i) == lane_idx)
                  lane_reg[i*PIX_WIDTH +: PIX_WIDTH] <= pix_data;
            lane_cnt <= lane_idx + LANE_W'(1);
         end else if (frame_start) begin
            lane_cnt <= '0;
         end
         if (pix_valid && !pix_ready)
            overflow <= 1'b1;
         fill_level <= fill_nxt;
         pix_ready  <= (fill_nxt < FILL_W'(DEPTH));
         s1     <= burst_done_tgl;
         s2     <= s1;
         s3     <= s2;
         done_q <= s2 ^ s3;
      end
   end

   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // One outstanding request at a time; completion advances the read base
   always_comb begin
      state_nxt = state;
      req_fire  = 1'b0;
      rd_adv    = 1'b0;
      case (state)
         S_IDLE: if (pend_cnt != '0) begin
            req_fire  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: if (done_q) begin
            rd_adv    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) begin
         pend_cnt      <= '0;
         burst_req_tgl <= 1'b0;
         burst_addr    <= '0;
         rd_base       <= '0;
      end else begin
         pend_cnt <= pend_cnt + FILL_W'(pend_inc) - FILL_W'(req_fire);
         if (req_fire) begin
            burst_req_tgl <= ~burst_req_tgl;
            burst_addr    <= rd_base;
         end
         if (rd_adv)
            rd_base <= rd_base + ADDR_WIDTH'(BURST_LEN);
      end
   end

endmodule

// File: tb/tb_wr_fram_pack.sv
// Self-checking bench for wr_fram_pack: vector table, directed burst/overflow/reset sequences,
// and a randomized stream checked against a queue-based model of expected RAM writes.
module tb_wr_fram_pack;
   localparam int BL    = 64;
   localparam int DEPTH = 512;

   logic         wr_clk = 1'b0;
   logic         tb_wr_rst, frame_start, pix_valid, pix_ready;
   logic         buf_wr_en, burst_req_tgl, burst_done_tgl, overflow;
   logic [31:0]  pix_data;
   logic [255:0] buf_wr_data;
   logic [8:0]   buf_wr_addr, burst_addr;
   logic [9:0]   fill_level;

   wr_fram_pack dut (
      .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .frame_start(frame_start),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .buf_wr_data(buf_wr_data), .buf_wr_addr(buf_wr_addr), .buf_wr_en(buf_wr_en),
      .burst_req_tgl(burst_req_tgl), .burst_addr(burst_addr),
      .burst_done_tgl(burst_done_tgl), .fill_level(fill_level), .overflow(overflow)
   );

   always #5 wr_clk = ~wr_clk;

   typedef struct { logic [8:0] addr; logic [255:0] data; } wr_t;
   typedef struct {
      bit v; bit fs; logic [31:0] d;
      bit en; logic [8:0] addr; logic [9:0] fill; bit dchk; logic [255:0] data;
   } vec_t;

   wr_t         exp_q[$];
   wr_t         mon_w;
   vec_t        tbl[18];
   logic [31:0] m_lane[8];
   logic [8:0]  m_ptr, exp_baddr;
   int          m_cnt, m_words, m_acks;
   int          checks, failures, n_req, n_wr;
   bit          req_out, auto_ack;
   logic        last_req;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: collect lanes, emit a word on the 8th pixel (or on a flushing frame_start)
   task automatic push_word(input int nl);
      wr_t w;
      w.data = '0;
      for (int i = 0; i < nl; i++) w.data[i*32 +: 32] = m_lane[i];
      w.addr = m_ptr;
      exp_q.push_back(w);
      m_ptr++;
      m_words++;
   endtask

   task automatic cycle(input bit v, input bit fs, input logic [31:0] d);
      @(negedge wr_clk);
      pix_valid = v; frame_start = fs; pix_data = d;
      if (fs) begin
`ifdef WR_FRAM_FLUSH_EN
         if (m_cnt != 0) push_word(m_cnt);
`endif
         m_cnt = 0;
      end
      if (v && (m_words - BL * m_acks) < DEPTH) begin
         m_lane[m_cnt] = d;
         m_cnt++;
         if (m_cnt == 8) begin
            push_word(8);
            m_cnt = 0;
         end
      end
      @(posedge wr_clk);
      #1;
   endtask

   task automatic stream(input int n, input bit rnd);
      int sent;
      bit v, fs;
      sent = 0;
      while (sent < n) begin
         v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         fs = rnd && (m_cnt == 0) && ($urandom_range(0, 15) == 0);
         if (v) begin
            cycle(1'b1, fs, $urandom);
            sent++;
         end else begin
            cycle(1'b0, fs, 32'h0);
         end
      end
      cycle(1'b0, 1'b0, 32'h0);
   endtask

   task automatic wait_req(input int target);
      int k;
      k = 0;
      while (n_req < target && k < 100) begin
         cycle(1'b0, 1'b0, 32'h0);
         k++;
      end
      chk("req_count", n_req, target);
   endtask

   // Done toggle reaches the sync edge after 3 clocks; occupancy drops on the 4th
   task automatic ack_check();
      int f0;
      f0 = m_words - BL * m_acks;
      @(negedge wr_clk);
      burst_done_tgl = ~burst_done_tgl;
      req_out = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      chk("fill_before_done", fill_level, f0);
      @(posedge wr_clk);
      #1;
      chk("fill_after_done", fill_level, f0 - BL);
      m_acks++;
   endtask

   task automatic do_reset();
      @(negedge wr_clk);
      tb_wr_rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; pix_data = '0;
      burst_done_tgl = 1'b0; auto_ack = 1'b0;
      #1;
      chk("rst_wr_en", buf_wr_en, 0);
      chk("rst_wr_data", buf_wr_data, 0);
      chk("rst_wr_addr", buf_wr_addr, 0);
      chk("rst_req_tgl", burst_req_tgl, 0);
      chk("rst_burst_addr", burst_addr, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_ready", pix_ready, 1);
      exp_q.delete();
      m_cnt = 0; m_words = 0; m_acks = 0; m_ptr = '0;
      req_out = 1'b0; last_req = 1'b0; exp_baddr = '0; n_req = 0; n_wr = 0;
      repeat (2) @(posedge wr_clk);
      @(negedge wr_clk);
      tb_wr_rst = 1'b0;
   endtask

   // Write and request monitor against the model
   always begin
      @(posedge wr_clk);
      #1;
      if (tb_wr_rst === 1'b0) begin
         if (buf_wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               chk("unexpected_wr_en", buf_wr_en, 0);
            end else begin
               mon_w = exp_q.pop_front();
               chk("wr_addr", buf_wr_addr, mon_w.addr);
               chk("wr_data", buf_wr_data, mon_w.data);
            end
         end
         if (burst_req_tgl !== last_req) begin
            last_req = burst_req_tgl;
            n_req++;
            chk("req_while_outstanding", req_out, 0);
            chk("burst_addr", burst_addr, exp_baddr);
            exp_baddr = exp_baddr + 9'd64;
            req_out = 1'b1;
         end
      end
   end

   // DDR-side responder for the randomized phase
   initial forever begin
      @(negedge wr_clk);
      if (auto_ack && req_out) begin
         repeat ($urandom_range(0, 20)) @(negedge wr_clk);
         burst_done_tgl = ~burst_done_tgl;
         req_out = 1'b0;
         repeat (6) @(posedge wr_clk);
         m_acks++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      checks = 0; failures = 0;
      tb_wr_rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; pix_data = '0;
      burst_done_tgl = 1'b0; auto_ack = 1'b0; req_out = 1'b0; last_req = 1'b0;

      for (int i = 0; i < 18; i++) begin
         tbl[i] = '{v: 1'b0, fs: 1'b0, d: 32'h0, en: 1'b0, addr: 9'd0, fill: 10'd0,
                    dchk: 1'b0, data: '0};
      end
      for (int i = 0; i < 8; i++) begin
         tbl[i].v = 1'b1; tbl[i].d = 32'(i);
         tbl[i].fill = (i == 7) ? 10'd1 : 10'd0;
      end
      tbl[7].en = 1'b1; tbl[7].dchk = 1'b1;
      tbl[7].data = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
      tbl[8].fill = 10'd1;
      tbl[9].v = 1'b1; tbl[9].fs = 1'b1; tbl[9].d = 32'h100; tbl[9].fill = 10'd1;
      for (int i = 10; i < 17; i++) begin
         tbl[i].v = 1'b1; tbl[i].d = 32'h100 + 32'(i - 9); tbl[i].fill = 10'd1;
      end
      tbl[16].en = 1'b1; tbl[16].addr = 9'd1; tbl[16].fill = 10'd2;
      tbl[17].addr = 9'd1; tbl[17].fill = 10'd2;

      do_reset();
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].v, tbl[i].fs, tbl[i].d);
         chk($sformatf("t%0d_wr_en", i), buf_wr_en, tbl[i].en);
         chk($sformatf("t%0d_wr_addr", i), buf_wr_addr, tbl[i].addr);
         chk($sformatf("t%0d_fill", i), fill_level, tbl[i].fill);
         chk($sformatf("t%0d_ready", i), pix_ready, 1);
         if (tbl[i].dchk) chk($sformatf("t%0d_wr_data", i), buf_wr_data, tbl[i].data);
      end

      // One burst, then eight more with acknowledgements; ring and base both wrap
      do_reset();
      stream(512, 1'b0);
      wait_req(1);
      chk("fill_one_burst", fill_level, 64);
      ack_check();
      for (int b = 0; b < 8; b++) begin
         stream(512, 1'b0);
         wait_req(b + 2);
         ack_check();
      end
      chk("nine_burst_writes", n_wr, 576);
      chk("nine_burst_last_addr", buf_wr_addr, 63);
      chk("nine_burst_queue_empty", exp_q.size(), 0);

      // Fill the buffer without acknowledgements, then drop a pixel
      do_reset();
      stream(4096, 1'b0);
      wait_req(1);
      chk("full_fill", fill_level, 512);
      chk("full_ready", pix_ready, 0);
      chk("full_no_overflow_yet", overflow, 0);
      cycle(1'b1, 1'b0, 32'hDEADBEEF);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("ovf_set", overflow, 1);
      chk("ovf_addr_held", buf_wr_addr, 511);
      chk("ovf_fill_held", fill_level, 512);
      chk("ovf_write_count", n_wr, 512);

      // Reset while a request is outstanding; the FSM must come back IDLE
      do_reset();
      stream(512, 1'b0);
      wait_req(1);
      chk("wait_fill", fill_level, 64);
      do_reset();
      stream(512, 1'b0);
      wait_req(1);
      ack_check();

      // Partial word at frame_start
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'hA0 + 32'(i));
      cycle(1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'hB0 + 32'(i));
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
`ifdef WR_FRAM_FLUSH_EN
      chk("partial_writes", n_wr, 2);
      chk("partial_fill", fill_level, 2);
      chk("partial_last_addr", buf_wr_addr, 1);
`else
      chk("partial_writes", n_wr, 1);
      chk("partial_fill", fill_level, 1);
      chk("partial_last_addr", buf_wr_addr, 0);
`endif

      // Randomized gaps, data, frame_start at word boundaries and ack delays
      do_reset();
      auto_ack = 1'b1;
      stream(2048, 1'b1);
      k = 0;
      while ((n_req < 4 || req_out || m_acks < 4) && k < 2000) begin
         cycle(1'b0, 1'b0, 32'h0);
         k++;
      end
      auto_ack = 1'b0;
      chk("rand_req_count", n_req, 4);
      chk("rand_acks", m_acks, 4);
      chk("rand_fill", fill_level, 0);
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_overflow", overflow, 0);
      chk("rand_ready", pix_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
